data_mem_if: RTL and testbench

DATA_MEM_IF -- requirements
Module: data_mem_if

---
 rtl/data_mem_if.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_if.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Load/store bridge between the core datapath and a single-beat acked memory port.
// Handles lane alignment, sign/zero extension, access faults and ack timeout.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a legal, aligned MemRead/MemWrite; latches request
// S_REQ  | memReq held high until memAck or the cycle counter expires
// S_DONE | one bubble cycle with stall released, then back to S_IDLE
module data_mem_if #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] rd2,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        accessFault,
    output logic        timeout,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memBe,
    input  logic [31:0] memRdata,
    input  logic        memAck
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic          access;
    logic          is_store;
    logic          f3_legal;
    logic          aligned;
    logic          accept;
    logic          reject;
    logic          cnt_last;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   load_ext;
    logic [31:0]   byte_shift;
    logic [31:0]   half_shift;

    logic [31:0]   addr_q;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;

    // Request qualification against the live IDLE-cycle inputs
    always_comb begin
        access   = MemRead | MemWrite;
        is_store = MemWrite;
        f3_legal = 1'b0;
        aligned  = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ~is_store;
            default:                f3_legal = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   aligned = ~ALUResult[0];
            2'b10:   aligned = (ALUResult[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        accept = (state_q == S_IDLE) & access & f3_legal & aligned;
        reject = (state_q == S_IDLE) & access & ~(f3_legal & aligned);
    end

    // Store lane steering; loads carry no byte enables
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'h0000_0000;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << ALUResult[1:0];
                    st_wdata = {4{rd2[7:0]}};
                end
                2'b01: begin
                    st_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{rd2[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = rd2;
                end
            endcase
        end
    end

    always_comb begin
        byte_shift = memRdata >> {off_q, 3'b000};
        half_shift = memRdata >> {off_q[1], 4'b0000};
        case (f3_q)
            3'b000:  load_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_ext = {{16{half_shift[15]}}, half_shift[15:0]};
            3'b100:  load_ext = {24'h00_0000, byte_shift[7:0]};
            3'b101:  load_ext = {16'h0000, half_shift[15:0]};
            default: load_ext = memRdata;
        endcase
    end

    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ:  if (memAck || cnt_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Stall and fault are forced low while reset is held, regardless of inputs
    always_comb begin
        memReq      = (state_q == S_REQ);
        stall       = reset & (accept | (state_q == S_REQ));
        accessFault = reset & reject;
        memWe       = memReq & we_q;
        memBe       = memReq ? be_q : 4'b0000;
        memWdata    = memReq ? wdata_q : 32'h0000_0000;
        memAddr     = addr_q;
        timeout     = timeout_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= 32'h0000_0000;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0000_0000;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            ReadData  <= 32'h0000_0000;
        end else if (accept) begin
            addr_q  <= {ALUResult[31:2], 2'b00};
            off_q   <= ALUResult[1:0];
            f3_q    <= funct3;
            we_q    <= is_store;
            be_q    <= st_be;
            wdata_q <= st_wdata;
            cnt_q   <= '0;
        end else if (state_q == S_REQ) begin
            if (memAck) begin
                if (!we_q) ReadData <= load_ext;
            end else if (cnt_last) begin
                timeout_q <= 1'b1;
                if (!we_q) ReadData <= 32'h0000_0000;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_if.sv
// Directed bench for data_mem_if: load/store lanes, faults, timeout and reset abort.
module tb_data_mem_if;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  funct3;
    logic [31:0] ALUResult;
    logic [31:0] rd2;
    logic [31:0] ReadData;
    logic        stall;
    logic        accessFault;
    logic        timeout;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic [31:0] memRdata;
    logic        memAck;

    int n_pass;
    int n_total;

    data_mem_if #(.TIMEOUT(16)) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .funct3(funct3),
        .ALUResult(ALUResult),
        .rd2(rd2),
        .ReadData(ReadData),
        .stall(stall),
        .accessFault(accessFault),
        .timeout(timeout),
        .memReq(memReq),
        .memWe(memWe),
        .memAddr(memAddr),
        .memWdata(memWdata),
        .memBe(memBe),
        .memRdata(memRdata),
        .memAck(memAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        memAck   = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b1;
        funct3    = 3'b011;
        ALUResult = 32'h0;
        rd2       = 32'h0;
        memRdata  = 32'h0;
        memAck    = 1'b0;

        // Reset state; illegal and legal requests must not raise fault/stall
        #12;
        check("rst_memReq", {31'd0, memReq}, 32'd0);
        check("rst_memBe", {28'd0, memBe}, 32'd0);
        check("rst_memWdata", memWdata, 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        check("rst_ReadData", ReadData, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_fault", {31'd0, accessFault}, 32'd0);
        funct3 = 3'b010;
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);

        // lb 0x1003, ack in first REQ cycle, accepted on first edge after reset
        @(posedge clk);
        #1;
        reset     = 1'b1;
        MemRead   = 1'b1;
        funct3    = 3'b000;
        ALUResult = 32'h0000_1003;
        #1;
        check("lb_idle_stall", {31'd0, stall}, 32'd1);
        check("lb_idle_req", {31'd0, memReq}, 32'd0);
        tick();
        MemRead   = 1'b0;
        ALUResult = 32'h0000_FFFF;
        memRdata  = 32'h80AA_BBCC;
        memAck    = 1'b1;
        #1;
        check("lb_req", {31'd0, memReq}, 32'd1);
        check("lb_stall", {31'd0, stall}, 32'd1);
        check("lb_addr", memAddr, 32'h0000_1000);
        check("lb_we", {31'd0, memWe}, 32'd0);
        check("lb_be", {28'd0, memBe}, 32'd0);
        tick();
        memAck = 1'b0;
        check("lb_done_stall", {31'd0, stall}, 32'd0);
        check("lb_done_req", {31'd0, memReq}, 32'd0);
        check("lb_data", ReadData, 32'hFFFF_FF80);
        tick();

        // sh 0x2002
        MemWrite  = 1'b1;
        funct3    = 3'b001;
        ALUResult = 32'h0000_2002;
        rd2       = 32'h1234_ABCD;
        #1;
        check("sh_idle_stall", {31'd0, stall}, 32'd1);
        check("sh_idle_be", {28'd0, memBe}, 32'd0);
        tick();
        MemWrite = 1'b0;
        rd2      = 32'h0;
        memAck   = 1'b1;
        #1;
        check("sh_we", {31'd0, memWe}, 32'd1);
        check("sh_be", {28'd0, memBe}, 32'hC);
        check("sh_wdata", memWdata, 32'hABCD_ABCD);
        check("sh_addr", memAddr, 32'h0000_2000);
        tick();
        memAck = 1'b0;
        check("sh_done_be", {28'd0, memBe}, 32'd0);
        check("sh_done_wdata", memWdata, 32'd0);
        check("sh_rdata_kept", ReadData, 32'hFFFF_FF80);
        tick();

        // Faults: misaligned lw, lbu-as-store, funct3 011, both-high treated as store
        MemRead   = 1'b1;
        funct3    = 3'b010;
        ALUResult = 32'h0000_0006;
        #1;
        check("lw_mis_fault", {31'd0, accessFault}, 32'd1);
        check("lw_mis_stall", {31'd0, stall}, 32'd0);
        tick();
        check("lw_mis_noreq", {31'd0, memReq}, 32'd0);
        MemRead = 1'b0;
        #1;
        check("fault_pulse_end", {31'd0, accessFault}, 32'd0);
        MemWrite  = 1'b1;
        funct3    = 3'b100;
        ALUResult = 32'h0000_0000;
        #1;
        check("sbu_fault", {31'd0, accessFault}, 32'd1);
        MemRead = 1'b1;
        #1;
        check("both_sbu_fault", {31'd0, accessFault}, 32'd1);
        MemWrite = 1'b0;
        funct3   = 3'b011;
        #1;
        check("f3_011_fault", {31'd0, accessFault}, 32'd1);
        tick();
        check("fault_noreq", {31'd0, memReq}, 32'd0);
        check("fault_rdata_kept", ReadData, 32'hFFFF_FF80);
        funct3 = 3'b111;
        #1;
        check("half_mis_none", {31'd0, stall}, 32'd0);
        funct3    = 3'b001;
        ALUResult = 32'h0000_0003;
        #1;
        check("lh_mis_fault", {31'd0, accessFault}, 32'd1);
        MemWrite  = 1'b1;
        funct3    = 3'b010;
        ALUResult = 32'h0000_0040;
        rd2       = 32'h7777_0001;
        tick();
        idle_inputs();
        memAck = 1'b1;
        #1;
        check("both_we", {31'd0, memWe}, 32'd1);
        check("both_be", {28'd0, memBe}, 32'hF);
        tick();
        memAck = 1'b0;
        tick();

        // lw 0x100 with ack on the last allowed REQ cycle: success, no timeout
        MemRead   = 1'b1;
        funct3    = 3'b010;
        ALUResult = 32'h0000_0100;
        tick();
        MemRead = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick();
            check($sformatf("lw_late_req%0d", i), {31'd0, memReq}, 32'd1);
        end
        memAck   = 1'b1;
        memRdata = 32'h5A5A_1234;
        tick();
        memAck = 1'b0;
        check("lw_late_done", {31'd0, memReq}, 32'd0);
        check("lw_late_data", ReadData, 32'h5A5A_1234);
        check("lw_late_tmo", {31'd0, timeout}, 32'd0);
        tick();

        // lhu 0x0002 with ack withheld: abort after 16 REQ cycles
        MemRead   = 1'b1;
        funct3    = 3'b101;
        ALUResult = 32'h0000_0002;
        tick();
        MemRead = 1'b0;
        for (int i = 2; i <= 16; i++) tick();
        check("lhu_req16", {31'd0, memReq}, 32'd1);
        check("lhu_tmo_pre", {31'd0, timeout}, 32'd0);
        tick();
        check("lhu_done_req", {31'd0, memReq}, 32'd0);
        check("lhu_tmo", {31'd0, timeout}, 32'd1);
        check("lhu_data0", ReadData, 32'd0);
        tick();
        memAck   = 1'b1;
        memRdata = 32'hDEAD_BEEF;
        #1;
        check("idle_ack_req", {31'd0, memReq}, 32'd0);
        check("idle_ack_stall", {31'd0, stall}, 32'd0);
        tick();
        memAck = 1'b0;
        check("idle_ack_data", ReadData, 32'd0);
        check("tmo_sticky", {31'd0, timeout}, 32'd1);

        // Reset asserted mid-REQ
        MemRead   = 1'b1;
        funct3    = 3'b010;
        ALUResult = 32'h0000_0008;
        tick();
        MemRead = 1'b0;
        check("rreq_req", {31'd0, memReq}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rreq_drop", {31'd0, memReq}, 32'd0);
        check("rreq_tmo_clr", {31'd0, timeout}, 32'd0);
        #1;
        reset = 1'b1;
        tick();
        memAck   = 1'b1;
        memRdata = 32'hCAFE_1111;
        tick();
        memAck = 1'b0;
        check("rreq_ack_req", {31'd0, memReq}, 32'd0);
        check("rreq_ack_data", ReadData, 32'd0);

        // Back-to-back sw then lbu at 0x10
        MemWrite  = 1'b1;
        funct3    = 3'b010;
        ALUResult = 32'h0000_0010;
        rd2       = 32'hCAFE_F00D;
        #1;
        check("sw_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        MemWrite = 1'b0;
        memAck   = 1'b1;
        #1;
        check("sw_be", {28'd0, memBe}, 32'hF);
        check("sw_wdata", memWdata, 32'hCAFE_F00D);
        check("sw_addr", memAddr, 32'h0000_0010);
        tick();
        memAck    = 1'b0;
        MemRead   = 1'b1;
        funct3    = 3'b100;
        ALUResult = 32'h0000_0010;
        #1;
        check("sw_done_stall", {31'd0, stall}, 32'd0);
        check("sw_done_req", {31'd0, memReq}, 32'd0);
        tick();
        check("lbu_idle_stall", {31'd0, stall}, 32'd1);
        check("lbu_idle_req", {31'd0, memReq}, 32'd0);
        tick();
        MemRead  = 1'b0;
        memAck   = 1'b1;
        memRdata = 32'h1234_56F5;
        #1;
        check("lbu_req", {31'd0, memReq}, 32'd1);
        check("lbu_we", {31'd0, memWe}, 32'd0);
        tick();
        memAck = 1'b0;
        check("lbu_data", ReadData, 32'h0000_00F5);
        check("lbu_done_req", {31'd0, memReq}, 32'd0);
        tick();
        check("final_idle_stall", {31'd0, stall}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
